// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage SRAM load/store sequencer; define MEM_ALIGN_CHECK_EN to turn misaligned accesses into error responses
module mem_access_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        stallreq
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
  state_t state_q, state_d;
  logic we_q, we_d, uns_q, uns_d, mis_q, mis_d;
  logic [1:0] size_q, size_d;
  logic [2:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic req_mis;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_fmt;
`ifdef MEM_ALIGN_CHECK_EN
  assign req_mis = (req_size == 2'd1 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    mis_d   = mis_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        size_d  = req_size;
        uns_d   = req_unsigned;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        mis_d   = req_mis;
        state_d = req_mis ? RESP : ACCESS;
      end
      ACCESS: begin
        state_d = (we_q || RD_LAT == 1) ? RESP : WAIT;
        cnt_d   = LAT_M1;
        rdata_d = (!we_q && RD_LAT == 1) ? data_sram_rdata : rdata_q;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? RESP : WAIT;
        rdata_d = (cnt_q == 3'd1) ? data_sram_rdata : rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= 2'd0;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      mis_q   <= mis_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // Load lane select and extension work on the captured word so resp_rdata stays off the request path.
  always_comb begin
    lane_b = addr_q[1] ? (addr_q[0] ? rdata_q[31:24] : rdata_q[23:16])
                       : (addr_q[0] ? rdata_q[15:8] : rdata_q[7:0]);
    lane_h = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    ld_fmt = size_q == 2'd0 ? {{24{~uns_q & lane_b[7]}}, lane_b}
           : size_q == 2'd1 ? {{16{~uns_q & lane_h[15]}}, lane_h}
           : rdata_q;
  end
  always_comb begin
    req_ready       = state_q == IDLE;
    stallreq        = (state_q == IDLE && req_valid) || state_q == ACCESS || state_q == WAIT;
    data_sram_en    = state_q == ACCESS;
    data_sram_wen   = !(state_q == ACCESS && we_q) ? 4'b0000
                    : size_q == 2'd0 ? 4'b0001 << addr_q[1:0]
                    : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011)
                    : 4'b1111;
    data_sram_addr  = state_q == ACCESS ? {addr_q[31:2], 2'b00} : 32'd0;
    data_sram_wdata = state_q != ACCESS ? 32'd0
                    : size_q == 2'd0 ? {4{wdata_q[7:0]}}
                    : size_q == 2'd1 ? {2{wdata_q[15:0]}}
                    : wdata_q;
    resp_valid      = state_q == RESP;
    resp_rdata      = (state_q == RESP && !we_q && !mis_q) ? ld_fmt : 32'd0;
    misalign        = state_q == RESP && mis_q;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random and directed accesses on RD_LAT=1 and RD_LAT=3 instances against a transaction-level model
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        en [2];
  logic [3:0]  wen [2];
  logic [31:0] saddr [2];
  logic [31:0] swdata [2];
  logic [31:0] srdata [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        misalign [2];
  logic        stallreq [2];
  int n_cmp = 0;
  int n_bad = 0;
  mem_access_ctrl #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .data_sram_en(en[0]),
    .data_sram_wen(wen[0]), .data_sram_addr(saddr[0]), .data_sram_wdata(swdata[0]),
    .data_sram_rdata(srdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .misalign(misalign[0]), .stallreq(stallreq[0]));
  mem_access_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .data_sram_en(en[1]),
    .data_sram_wen(wen[1]), .data_sram_addr(saddr[1]), .data_sram_wdata(swdata[1]),
    .data_sram_rdata(srdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .misalign(misalign[1]), .stallreq(stallreq[1]));
  task automatic chk(input string nm, input int lat, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat=%0d got=%h want=%h", nm, lat, act, exp);
    end
  endtask
  task automatic garbage(input int k);
    req_valid[k]    = 1'($urandom);
    req_we[k]       = 1'($urandom);
    req_size[k]     = 2'($urandom);
    req_unsigned[k] = 1'($urandom);
    req_addr[k]     = $urandom;
    req_wdata[k]    = $urandom;
  endtask
  task automatic idle_chk(input int k);
    int lat;
    lat = k ? 3 : 1;
    req_valid[k] = 1'b0;
    @(negedge clk);
    chk("idle_ready", lat, 32'(req_ready[k]), 32'd1);
    chk("idle_stall", lat, 32'(stallreq[k]), 32'd0);
    chk("idle_en", lat, 32'(en[k]), 32'd0);
    chk("idle_wen", lat, 32'(wen[k]), 32'd0);
    chk("idle_addr", lat, saddr[k], 32'd0);
    chk("idle_wdata", lat, swdata[k], 32'd0);
    chk("idle_rvalid", lat, 32'(resp_valid[k]), 32'd0);
    chk("idle_rdata", lat, resp_rdata[k], 32'd0);
    chk("idle_misalign", lat, 32'(misalign[k]), 32'd0);
    @(posedge clk);
    #1;
  endtask
  // One access from request to completion; expectations follow the access rules, not the controller's states.
  task automatic txn(input int k, input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ld,
                     input logic lit_en, input logic [31:0] lit_rd, input logic [3:0] lit_wen,
                     input logic [31:0] lit_wd, input logic do_rst);
    int lat, n, rc;
    logic mis, act;
    logic [7:0] b;
    logic [15:0] h;
    logic [3:0] ew;
    logic [31:0] ewd, erd;
    lat = k ? 3 : 1;
    rc = lat > 1 ? 2 : 1;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
`endif
    n = mis ? 1 : we ? 2 : lat + 1;
    b = 8'(ld >> (8 * a[1:0]));
    h = 16'(ld >> (16 * a[1]));
    ew = !we ? 4'h0 : sz == 2'd0 ? 4'(1 << a[1:0]) : sz == 2'd1 ? (a[1] ? 4'hC : 4'h3) : 4'hF;
    ewd = sz == 2'd0 ? {4{wd[7:0]}} : sz == 2'd1 ? {2{wd[15:0]}} : wd;
    erd = (we || mis) ? 32'd0
        : sz == 2'd0 ? (un ? {24'd0, b} : {{24{b[7]}}, b})
        : sz == 2'd1 ? (un ? {16'd0, h} : {{16{h[15]}}, h})
        : ld;
    req_valid[k]    = 1'b1;
    req_we[k]       = we;
    req_size[k]     = sz;
    req_unsigned[k] = un;
    req_addr[k]     = a;
    req_wdata[k]    = wd;
    srdata[k]       = $urandom;
    @(negedge clk);
    chk("acc_ready", lat, 32'(req_ready[k]), 32'd1);
    chk("acc_stall", lat, 32'(stallreq[k]), 32'd1);
    chk("acc_en", lat, 32'(en[k]), 32'd0);
    chk("acc_rvalid", lat, 32'(resp_valid[k]), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 1; i <= n; i++) begin
      garbage(k);
      srdata[k] = (!we && !mis && i == lat) ? ld : $urandom;
      if (do_rst && i == rc) rst[k] = 1'b1;
      act = (i == 1) && !mis;
      @(negedge clk);
      chk("en", lat, 32'(en[k]), 32'(act));
      chk("wen", lat, 32'(wen[k]), act ? 32'(ew) : 32'd0);
      chk("addr", lat, saddr[k], act ? {a[31:2], 2'b00} : 32'd0);
      chk("wdata", lat, swdata[k], act ? ewd : 32'd0);
      chk("stallreq", lat, 32'(stallreq[k]), 32'(i < n));
      chk("ready", lat, 32'(req_ready[k]), 32'd0);
      chk("resp_valid", lat, 32'(resp_valid[k]), 32'(i == n));
      chk("resp_rdata", lat, resp_rdata[k], i == n ? erd : 32'd0);
      chk("misalign", lat, 32'(misalign[k]), 32'(i == n && mis));
      if (lit_en && act) begin
        chk("lit_wen", lat, 32'(wen[k]), 32'(lit_wen));
        chk("lit_wdata", lat, swdata[k], lit_wd);
      end
      if (lit_en && i == n) begin
        chk("lit_rdata", lat, resp_rdata[k], lit_rd);
        chk("lit_model", lat, erd, lit_rd);
      end
      @(posedge clk);
      #1;
      if (do_rst && i == rc) begin
        rst[k] = 1'b0;
        repeat (3) idle_chk(k);
        return;
      end
    end
    req_valid[k] = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      req_valid[k] = 1'b0;
      req_we[k] = 1'b0;
      req_size[k] = 2'd0;
      req_unsigned[k] = 1'b0;
      req_addr[k] = 32'd0;
      req_wdata[k] = 32'd0;
      srdata[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle_chk(k);
      txn(k, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8000_00F0, 1'b1, 32'h8000_00F0, 4'h0, 32'h0, 1'b0);
      idle_chk(k);
      txn(k, 1'b1, 2'd0, 1'b0, 32'h1003, 32'hAB, 32'h0, 1'b1, 32'h0, 4'b1000, 32'hABAB_ABAB, 1'b0);
      txn(k, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_80FF, 4'h0, 32'h0, 1'b0);
      txn(k, 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'h80FF_0000, 1'b1, 32'h0000_80FF, 4'h0, 32'h0, 1'b0);
      txn(k, 1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80, 4'h0, 32'h0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
      txn(k, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h1234_5678, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0);
`else
      txn(k, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h1234_5678, 1'b1, 32'h1234_5678, 4'h0, 32'h0, 1'b0);
`endif
      txn(k, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      txn(k, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 4'h0, 32'h0, 1'b0);
      for (int t = 0; t < 200; t++) begin
        repeat ($urandom_range(0, 2)) idle_chk(k);
        txn(k, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
            1'b0, 32'h0, 4'h0, 32'h0, $urandom_range(0, 19) == 0);
      end
      idle_chk(k);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
